// File: rtl/ir_fetch_buffer.sv
// Instruction register with a prefetch queue: assembles INSTR_W-bit words from
// BUS_W-bit memory beats (MSB first) and issues them under valid/ready.
module ir_fetch_buffer #(
    parameter int INSTR_W = 16,
    parameter int BUS_W   = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BUS_W-1:0]           mem_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic                       flush,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [INSTR_W-1:0]         instr,
    output logic [3:0]                 OPcode,
    output logic [2:0]                 Rd,
    output logic [2:0]                 Rs1,
    output logic [2:0]                 Rs2,
    output logic [2:0]                 func,
    output logic [5:0]                 imm,
    output logic [11:0]                imm_address,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       fetch_busy
);

    localparam int BEATS = INSTR_W / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic [CW-1:0]      beat_cnt;
    logic [INSTR_W-1:0] asm_q;
    logic [INSTR_W-1:0] push_word;
    logic [INSTR_W-1:0] fifo_q [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [LW-1:0]      level_q;

    logic last_beat;
    logic full;
    logic accept;
    logic push;
    logic pop;

    assign last_beat = (beat_cnt == CW'(BEATS - 1));
    assign full      = (level_q == LW'(DEPTH));
    assign mem_ready = !flush && !(full && last_beat);
    assign accept    = mem_valid && mem_ready;
    assign push      = accept && last_beat;
    assign pop       = issue_valid && issue_ready && !flush;

    // Shifting each beat in from the LSB end lands beat k in the same slice as
    // a direct indexed write once all BEATS beats have arrived.
    always_comb begin
        push_word = (asm_q << BUS_W) | INSTR_W'(mem_data);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
            asm_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (flush) begin
            beat_cnt <= '0;
            asm_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else begin
            if (accept) begin
                asm_q    <= push_word;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (push) begin
                fifo_q[wr_ptr] <= push_word;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign issue_valid = (level_q != '0);
    assign instr       = issue_valid ? fifo_q[rd_ptr] : '0;
    assign level       = level_q;
    assign fetch_busy  = (beat_cnt != '0);

    assign OPcode      = instr[INSTR_W-1  -: 4];
    assign Rd          = instr[INSTR_W-5  -: 3];
    assign Rs1         = instr[INSTR_W-8  -: 3];
    assign Rs2         = instr[INSTR_W-11 -: 3];
    assign func        = instr[INSTR_W-14 -: 3];
    assign imm         = instr[INSTR_W-11 -: 6];
    assign imm_address = instr[INSTR_W-5  -: 12];

endmodule

// File: tb/tb_ir_fetch_buffer.sv
// Scoreboard bench for ir_fetch_buffer at default parameters.
module tb_ir_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  mem_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] instr;
    logic [3:0]  OPcode;
    logic [2:0]  Rd;
    logic [2:0]  Rs1;
    logic [2:0]  Rs2;
    logic [2:0]  func;
    logic [5:0]  imm;
    logic [11:0] imm_address;
    logic [1:0]  level;
    logic        fetch_busy;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    ir_fetch_buffer #(.INSTR_W(16), .BUS_W(4), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .mem_data(mem_data), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .flush(flush), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .instr(instr), .OPcode(OPcode), .Rd(Rd),
        .Rs1(Rs1), .Rs2(Rs2), .func(func), .imm(imm), .imm_address(imm_address),
        .level(level), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    // Pops and compares the scoreboard head whenever a pop happens this edge.
    task automatic tick();
        logic [15:0] e;
        if (reset_n && issue_valid && issue_ready && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got instr=%h, expected no word", instr);
            end else begin
                e = exp_q.pop_front();
                if (instr !== e) begin
                    bad++;
                    $display("FAIL pop_order: got instr=%h, expected %h", instr, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d);
        mem_data  = d;
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(w);
            beat(w[15-4*k -: 4]);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        issue_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        issue_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || level !== 2'd0) begin
            bad++;
            $display("FAIL drain: got level=%0d left=%0d, expected 0 and 0", level, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_data    = 4'($urandom);
            mem_valid   = 1'($urandom);
            flush       = 1'($urandom);
            issue_ready = 1'($urandom);
            tick();
            total++;
            if (issue_valid !== 1'b0 || instr !== 16'h0000 || level !== 2'd0 || fetch_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got v=%b instr=%h level=%0d busy=%b, expected 0/0000/0/0",
                         issue_valid, instr, level, fetch_busy);
            end
        end
        mem_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0; mem_data = '0;
        reset_n = 1'b1;
        #1;
        total++;
        if (mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got mem_ready=%b, expected 1", mem_ready);
        end
        tick();
    endtask

    task automatic test_assembly();
        send_word(16'h1234);
        total++;
        if (instr !== 16'h1234 || level !== 2'd1 || issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL assembly_word: got instr=%h level=%0d v=%b, expected 1234/1/1", instr, level, issue_valid);
        end
        total++;
        if (OPcode !== 4'd1 || Rd !== 3'd1 || Rs1 !== 3'd0 || Rs2 !== 3'd6 || func !== 3'd4 ||
            imm !== 6'h34 || imm_address !== 12'h234) begin
            bad++;
            $display("FAIL decode_fields: got op=%h rd=%0d rs1=%0d rs2=%0d func=%0d imm=%h ia=%h, expected 1/1/0/6/4/34/234",
                     OPcode, Rd, Rs1, Rs2, func, imm, imm_address);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        send_word(16'h1234);
        send_word(16'hABCD);
        total++;
        if (level !== 2'd2) begin
            bad++;
            $display("FAIL bp_full: got level=%0d, expected 2", level);
        end
        for (int k = 5; k <= 7; k++) begin
            total++;
            if (mem_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_nonlast_ready: got mem_ready=%b at beat %0d, expected 1", mem_ready, k);
            end
            beat(4'(k));
        end
        mem_data = 4'h8; mem_valid = 1'b1;
        #1;
        total++;
        if (mem_ready !== 1'b0 || fetch_busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall: got mem_ready=%b busy=%b, expected 0/1", mem_ready, fetch_busy);
        end
        tick();
        total++;
        if (mem_ready !== 1'b0 || level !== 2'd2) begin
            bad++;
            $display("FAIL bp_still_stalled: got mem_ready=%b level=%0d, expected 0/2", mem_ready, level);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        total++;
        if (mem_ready !== 1'b1 || level !== 2'd1 || instr !== 16'hABCD) begin
            bad++;
            $display("FAIL bp_after_pop: got mem_ready=%b level=%0d instr=%h, expected 1/1/abcd", mem_ready, level, instr);
        end
        exp_q.push_back(16'h5678);
        tick();
        mem_valid = 1'b0;
        total++;
        if (level !== 2'd2 || fetch_busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_last_accepted: got level=%0d busy=%b, expected 2/0", level, fetch_busy);
        end
        drain();
    endtask

    task automatic test_gapped();
        logic [15:0] words [3];
        words[0] = 16'hC3A5; words[1] = 16'h0F1E; words[2] = 16'h7B2D;
        issue_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) exp_q.push_back(words[w]);
                beat(words[w][15-4*k -: 4]);
                tick();
            end
        end
        tick();
        issue_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || level !== 2'd0) begin
            bad++;
            $display("FAIL gapped_all_out: got left=%0d level=%0d, expected 0/0", exp_q.size(), level);
        end
        send_word(16'h1357);
        for (int k = 0; k < 3; k++) beat(4'(k + 2));
        exp_q.push_back(16'h2345);
        issue_ready = 1'b1;
        beat(4'h5);
        issue_ready = 1'b0;
        total++;
        if (level !== 2'd1 || instr !== 16'h2345) begin
            bad++;
            $display("FAIL push_pop_level: got level=%0d instr=%h, expected 1/2345", level, instr);
        end
        drain();
    endtask

    task automatic test_flush();
        send_word(16'h4321);
        beat(4'hD);
        beat(4'hE);
        total++;
        if (fetch_busy !== 1'b1 || level !== 2'd1) begin
            bad++;
            $display("FAIL flush_pre: got busy=%b level=%0d, expected 1/1", fetch_busy, level);
        end
        flush = 1'b1; mem_valid = 1'b1; mem_data = 4'hF; issue_ready = 1'b1;
        #1;
        total++;
        if (mem_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got mem_ready=%b, expected 0", mem_ready);
        end
        tick();
        exp_q.delete();
        flush = 1'b0; mem_valid = 1'b0; issue_ready = 1'b0;
        total++;
        if (level !== 2'd0 || fetch_busy !== 1'b0 || issue_valid !== 1'b0 || instr !== 16'h0000) begin
            bad++;
            $display("FAIL flush_clear: got level=%0d busy=%b v=%b instr=%h, expected 0/0/0/0000",
                     level, fetch_busy, issue_valid, instr);
        end
        send_word(16'h9ABC);
        total++;
        if (instr !== 16'h9ABC || level !== 2'd1) begin
            bad++;
            $display("FAIL flush_refill: got instr=%h level=%0d, expected 9abc/1", instr, level);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send_word(16'h2468);
        beat(4'h1); beat(4'h3); beat(4'h5);
        total++;
        if (level !== 2'd1 || fetch_busy !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre: got level=%0d busy=%b, expected 1/1", level, fetch_busy);
        end
        #3;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (issue_valid !== 1'b0 || instr !== 16'h0000 || level !== 2'd0 || fetch_busy !== 1'b0 ||
            OPcode !== 4'd0 || imm_address !== 12'h000) begin
            bad++;
            $display("FAIL rmid_async: got v=%b instr=%h level=%0d busy=%b op=%h ia=%h, expected all 0",
                     issue_valid, instr, level, fetch_busy, OPcode, imm_address);
        end
        tick();
        tick();
        reset_n = 1'b1;
        send_word(16'hFEDC);
        total++;
        if (instr !== 16'hFEDC || level !== 2'd1) begin
            bad++;
            $display("FAIL rmid_fresh: got instr=%h level=%0d, expected fedc/1", instr, level);
        end
        drain();
    endtask

    initial begin
        reset_n = 1'b0; mem_data = '0; mem_valid = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        test_reset();
        test_assembly();
        test_back_pressure();
        test_gapped();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule
